// File: rtl/ingress_burst_sequencer_pkg.sv
// ============================================================================
// ingress_burst_sequencer_pkg : shared types and field layout for ingress_burst_sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

package ingress_burst_sequencer_pkg;

  localparam logic [3:0] NIF_MASTER_CMD_RDREQ = 4'h1;

  localparam int ADDR_W = 64;
  localparam int LEN_W  = 36;
  localparam int CMD_W  = ADDR_W + LEN_W;

  // Response packet layout
  localparam int RSP_ADDR_LSB  = 64;
  localparam int RSP_BYTES_LSB = 28;
  localparam int RSP_ERR_LSB   = 1;
  localparam int RSP_OK_BIT    = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_REQ    = 3'd2,
    ST_STREAM = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  function automatic logic [127:0] pack_rsp(input logic [ADDR_W-1:0] start_addr,
                                            input logic [LEN_W-1:0] bytes,
                                            input logic [6:0] code,
                                            input logic ok);
    return {start_addr, bytes, 20'h0, code, ok};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ingress_burst_sequencer_cmd_fifo.sv
// ============================================================================
// ingress_cmd_fifo : synchronous command FIFO with first-word-fall-through head
// Revision 1.0
// ============================================================================
`default_nettype none

module ingress_cmd_fifo #(
  parameter int WIDTH = 100,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ingress_burst_sequencer.sv
// ============================================================================
// ingress_burst_sequencer : queues read commands, splits them into boundary-safe bursts
// Revision 1.0
// ============================================================================
`default_nettype none

module ingress_burst_sequencer
  import ingress_burst_sequencer_pkg::*;
#(
  parameter int C_DATA_WIDTH      = 128,
  parameter int C_CMD_DEPTH       = 4,
  parameter int C_MAX_BURST_BYTES = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_accept,
  input  logic [127:0]                  cmd_payload,
  output logic                          master_request,
  input  logic                          master_request_ack,
  input  logic                          master_request_complete,
  input  logic [6:0]                    master_request_error,
  output logic [3:0]                    master_request_type,
  output logic [63:0]                   master_request_local_address,
  output logic [35:0]                   master_request_length,
  input  logic                          master_datain_src_rdy,
  output logic                          master_datain_dst_rdy,
  input  logic [C_DATA_WIDTH-1:0]       master_datain,
  output logic                          egress_valid,
  input  logic                          egress_ready,
  output logic [C_DATA_WIDTH-1:0]       egress_data,
  output logic                          egress_last,
  output logic                          rsp_valid,
  input  logic                          rsp_accept,
  output logic [127:0]                  rsp_payload,
  output logic                          busy,
  output logic [$clog2(C_CMD_DEPTH):0]  cmd_count
);

  localparam int BPB      = C_DATA_WIDTH / 8;
  localparam int BPB_LOG  = $clog2(BPB);
  localparam int MAXB_LOG = $clog2(C_MAX_BURST_BYTES);

  state_t              state;
  logic [ADDR_W-1:0]   addr, start_addr;
  logic [LEN_W-1:0]    len, bytes_done, burst_len, beats_left;
  logic                err, data_done, cmpl_seen, accept_en;
  logic [6:0]          err_code, code_seen;

  logic                fifo_full, fifo_empty, fifo_pop;
  logic [CMD_W-1:0]    fifo_head;
  logic                unused_payload_bits;

  assign unused_payload_bits = ^cmd_payload[27:0];

  // accept_en keeps cmd_accept low for the cycle that follows reset
  assign cmd_accept = accept_en & ~fifo_full;
  assign fifo_pop   = (state == ST_IDLE) & ~fifo_empty;

  ingress_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (C_CMD_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_valid & cmd_accept),
    .push_data ({cmd_payload[127:64], cmd_payload[63:28]}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (cmd_count)
  );

  // Burst size: never cross a C_MAX_BURST_BYTES boundary
  logic [36:0]      room;
  logic [LEN_W-1:0] burst_calc, beats_calc;
  assign room       = 37'(C_MAX_BURST_BYTES) - 37'(addr[MAXB_LOG-1:0]);
  assign burst_calc = ({1'b0, len} < room) ? len : 36'(room);
  assign beats_calc = 36'((37'(burst_calc) + 37'(BPB - 1)) >> BPB_LOG);

  logic       in_stream, beat_fire, last_beat, final_burst, data_end, cmpl_any;
  logic [6:0] code_any;
  assign in_stream   = (state == ST_STREAM);
  assign beat_fire   = in_stream & master_datain_src_rdy & egress_ready;
  assign last_beat   = (beats_left == 36'd1) & ~data_done;
  assign final_burst = (len == burst_len);
  assign data_end    = data_done | (beat_fire & last_beat);
  assign cmpl_any    = cmpl_seen | master_request_complete;
  assign code_any    = cmpl_seen ? code_seen : master_request_error;

  assign master_datain_dst_rdy        = in_stream & egress_ready;
  assign egress_valid                 = in_stream & master_datain_src_rdy;
  assign egress_data                  = in_stream ? master_datain : '0;
  assign egress_last                  = egress_valid & last_beat & final_burst;
  assign master_request_type          = NIF_MASTER_CMD_RDREQ;
  assign master_request_local_address = addr;
  assign master_request_length        = burst_len;
  assign rsp_payload                  = rsp_valid ? pack_rsp(start_addr, bytes_done, err_code, ~err) : '0;
  assign busy                         = (state != ST_IDLE) | ~fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      addr           <= '0;
      start_addr     <= '0;
      len            <= '0;
      bytes_done     <= '0;
      burst_len      <= '0;
      beats_left     <= '0;
      err            <= 1'b0;
      err_code       <= '0;
      data_done      <= 1'b0;
      cmpl_seen      <= 1'b0;
      code_seen      <= '0;
      master_request <= 1'b0;
      rsp_valid      <= 1'b0;
      accept_en      <= 1'b0;
    end else begin
      accept_en <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            addr       <= fifo_head[CMD_W-1:LEN_W];
            start_addr <= fifo_head[CMD_W-1:LEN_W];
            len        <= fifo_head[LEN_W-1:0];
            bytes_done <= '0;
            err        <= 1'b0;
            err_code   <= '0;
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          data_done <= 1'b0;
          cmpl_seen <= 1'b0;
          code_seen <= '0;
          if (len == '0) begin
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            burst_len      <= burst_calc;
            beats_left     <= beats_calc;
            master_request <= 1'b1;
            state          <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (master_request_ack) begin
            master_request <= 1'b0;
            state          <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (beat_fire && !data_done) beats_left <= beats_left - 1'b1;
          if (beat_fire && last_beat)  data_done  <= 1'b1;
          if (master_request_complete) begin
            cmpl_seen <= 1'b1;
            code_seen <= master_request_error;
          end
          // An error ends the command at once; outstanding beats are abandoned
          if (cmpl_any && code_any != 7'd0) begin
            err       <= 1'b1;
            err_code  <= code_any;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else if (cmpl_any && data_end) begin
            addr       <= addr + 64'(burst_len);
            bytes_done <= bytes_done + burst_len;
            len        <= len - burst_len;
            if (final_burst) begin
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_RESP: begin
          if (rsp_accept) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ingress_burst_sequencer.sv
// ============================================================================
// tb_ingress_burst_sequencer : scoreboard bench with a behavioural read master
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ingress_burst_sequencer;
  import ingress_burst_sequencer_pkg::*;

  localparam int DW = 128;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cmd_valid, cmd_accept;
  logic [127:0]   cmd_payload;
  logic           master_request, master_request_ack, master_request_complete;
  logic [6:0]     master_request_error;
  logic [3:0]     master_request_type;
  logic [63:0]    master_request_local_address;
  logic [35:0]    master_request_length;
  logic           master_datain_src_rdy, master_datain_dst_rdy;
  logic [DW-1:0]  master_datain;
  logic           egress_valid, egress_ready, egress_last;
  logic [DW-1:0]  egress_data;
  logic           rsp_valid, rsp_accept;
  logic [127:0]   rsp_payload;
  logic           busy;
  logic [2:0]     cmd_count;

  always #5 clk = ~clk;

  ingress_burst_sequencer #(
    .C_DATA_WIDTH (DW), .C_CMD_DEPTH (4), .C_MAX_BURST_BYTES (4096)
  ) dut (
    .clk (clk), .rst (rst),
    .cmd_valid (cmd_valid), .cmd_accept (cmd_accept), .cmd_payload (cmd_payload),
    .master_request (master_request), .master_request_ack (master_request_ack),
    .master_request_complete (master_request_complete), .master_request_error (master_request_error),
    .master_request_type (master_request_type),
    .master_request_local_address (master_request_local_address),
    .master_request_length (master_request_length),
    .master_datain_src_rdy (master_datain_src_rdy), .master_datain_dst_rdy (master_datain_dst_rdy),
    .master_datain (master_datain),
    .egress_valid (egress_valid), .egress_ready (egress_ready), .egress_data (egress_data),
    .egress_last (egress_last),
    .rsp_valid (rsp_valid), .rsp_accept (rsp_accept), .rsp_payload (rsp_payload),
    .busy (busy), .cmd_count (cmd_count)
  );

  typedef struct packed { logic [63:0] a; logic [35:0] l; } req_t;

  req_t          req_q[$];
  logic          eg_q[$];
  logic [127:0]  rsp_q[$];
  int            total = 0;
  int            bad = 0;
  logic [31:0]   tx_cnt = 0;
  logic [31:0]   rx_cnt = 0;
  bit            hold_ack = 0, early_cmpl = 0, toggle_rdy = 0, abort = 0;
  logic [6:0]    err_next = 7'd0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rsp_exp(input logic [63:0] a, input logic [35:0] b,
                                           input logic [6:0] code, input logic ok);
    return {a, b, 20'h0, code, ok};
  endfunction

  task automatic exp_req(input logic [63:0] a, input logic [35:0] l);
    req_t r;
    r.a = a; r.l = l;
    req_q.push_back(r);
  endtask

  task automatic exp_beats(input int n, input bit final_burst);
    for (int i = 0; i < n; i++) eg_q.push_back(final_burst && (i == n - 1));
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic push_cmd(input logic [63:0] a, input logic [35:0] l);
    int g = 0;
    cmd_valid   = 1'b1;
    cmd_payload = {a, l, 28'hA5C3F0E};
    #1;
    while (!cmd_accept && g < 500) begin
      @(negedge clk); #1; g++;
    end
    if (!cmd_accept) check("push_timeout", 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int g = 0;
    while ((req_q.size() != 0 || eg_q.size() != 0 || rsp_q.size() != 0 || busy) && g < 3000) begin
      @(negedge clk); g++;
    end
    check({name, "_drain"}, 128'(g < 3000), 128'(1));
  endtask

  // Behavioural read master: acks requests, streams beats, signals completion
  initial begin : master
    req_t r;
    int   nb, sent, guard;
    logic [6:0] e;
    master_request_ack = 0; master_request_complete = 0; master_request_error = 0;
    master_datain_src_rdy = 0; master_datain = '0;
    forever begin
      @(negedge clk);
      if (master_request && !hold_ack && !rst) begin
        master_request_ack = 1'b1;
        check("req_type", 128'(master_request_type), 128'(NIF_MASTER_CMD_RDREQ));
        if (req_q.size() == 0) check("req_unexpected", 128'(master_request_local_address), 128'(0));
        else begin
          r = req_q.pop_front();
          check("req_addr", 128'(master_request_local_address), 128'(r.a));
          check("req_len", 128'(master_request_length), 128'(r.l));
        end
        nb = int'((master_request_length + 36'd15) / 36'd16);
        e = err_next;
        @(negedge clk);
        master_request_ack = 1'b0;
        if (e != 7'd0) begin
          master_request_complete = 1'b1; master_request_error = e; err_next = 7'd0;
          @(negedge clk);
          master_request_complete = 1'b0; master_request_error = 7'd0;
        end else begin
          sent = 0; guard = 0;
          while (sent < nb && !abort && guard < 2000) begin
            master_datain_src_rdy = 1'b1;
            master_datain = {4{tx_cnt}};
            master_request_complete = early_cmpl && (sent == 0);
            #1;
            if (master_datain_dst_rdy) begin sent++; tx_cnt++; end
            @(negedge clk);
            master_request_complete = 1'b0;
            guard++;
          end
          master_datain_src_rdy = 1'b0;
          if (guard >= 2000) check("beat_stall", 128'(sent), 128'(nb));
          if (!abort && !early_cmpl) begin
            master_request_complete = 1'b1;
            @(negedge clk);
            master_request_complete = 1'b0;
          end
        end
      end
    end
  end

  initial begin : ready_drv
    egress_ready = 1'b1;
    forever begin
      @(negedge clk);
      egress_ready = toggle_rdy ? ~egress_ready : 1'b1;
    end
  end

  initial begin : egress_mon
    logic x;
    forever begin
      @(negedge clk); #2;
      if (egress_valid && egress_ready) begin
        if (eg_q.size() == 0) check("egress_unexpected", 128'(egress_data), 128'(0));
        else begin
          x = eg_q.pop_front();
          check("egress_last", 128'(egress_last), 128'(x));
          check("egress_data", 128'(egress_data), 128'({4{rx_cnt}}));
        end
        rx_cnt++;
      end
    end
  end

  initial begin : rsp_mon
    logic [127:0] x;
    forever begin
      @(negedge clk); #2;
      if (rsp_valid && rsp_accept) begin
        if (rsp_q.size() == 0) check("rsp_unexpected", rsp_payload, 128'(0));
        else begin
          x = rsp_q.pop_front();
          check("rsp_payload", rsp_payload, x);
        end
      end
    end
  end

  initial begin : main
    cmd_valid = 1'b0; cmd_payload = '0; rsp_accept = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_accept", 128'(cmd_accept), 0);
    check("rst_request", 128'(master_request), 0);
    check("rst_rsp_valid", 128'(rsp_valid), 0);
    check("rst_egress_valid", 128'(egress_valid), 0);
    check("rst_busy", 128'(busy), 0);
    check("rst_count", 128'(cmd_count), 0);
    rst = 1'b0;
    @(negedge clk); #1;
    check("accept_after_rst", 128'(cmd_accept), 128'(1));

    // Single command with latency check
    @(negedge clk);
    exp_req(64'h1000, 36'd256); exp_beats(16, 1);
    rsp_q.push_back(rsp_exp(64'h1000, 36'd256, 7'd0, 1'b1));
    push_cmd(64'h1000, 36'd256);
    #1 check("lat_c1", 128'(master_request), 0);
    @(negedge clk); #1 check("lat_c2", 128'(master_request), 0);
    @(negedge clk); #1 check("lat_c3", 128'(master_request), 128'(1));
    wait_drain("single");

    // Boundary split
    @(negedge clk);
    exp_req(64'h0F80, 36'd128); exp_req(64'h1000, 36'd384);
    exp_beats(8, 0); exp_beats(24, 1);
    rsp_q.push_back(rsp_exp(64'h0F80, 36'd512, 7'd0, 1'b1));
    push_cmd(64'h0F80, 36'd512);
    wait_drain("split");

    // Queue full while the master withholds ack
    hold_ack = 1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      exp_req(64'h8000 + 64'(k) * 64'h100, 36'd32); exp_beats(2, 1);
      rsp_q.push_back(rsp_exp(64'h8000 + 64'(k) * 64'h100, 36'd32, 7'd0, 1'b1));
    end
    for (int k = 0; k < 5; k++) push_cmd(64'h8000 + 64'(k) * 64'h100, 36'd32);
    #1;
    check("full_count", 128'(cmd_count), 128'(4));
    check("full_accept", 128'(cmd_accept), 0);
    check("full_busy", 128'(busy), 128'(1));
    check("full_request", 128'(master_request), 128'(1));
    hold_ack = 0;
    wait_drain("full");

    // Error on the first of three bursts
    err_next = 7'h05;
    @(negedge clk);
    exp_req(64'h10000, 36'd4096);
    rsp_q.push_back(rsp_exp(64'h10000, 36'd0, 7'h05, 1'b0));
    push_cmd(64'h10000, 36'd12288);
    wait_drain("error");

    // Early completion with toggling egress_ready
    early_cmpl = 1; toggle_rdy = 1;
    @(negedge clk);
    exp_req(64'h3000, 36'd64); exp_beats(4, 1);
    rsp_q.push_back(rsp_exp(64'h3000, 36'd64, 7'd0, 1'b1));
    exp_req(64'h3FE0, 36'd32); exp_req(64'h4000, 36'd32);
    exp_beats(2, 0); exp_beats(2, 1);
    rsp_q.push_back(rsp_exp(64'h3FE0, 36'd64, 7'd0, 1'b1));
    push_cmd(64'h3000, 36'd64);
    push_cmd(64'h3FE0, 36'd64);
    wait_drain("early");
    early_cmpl = 0; toggle_rdy = 0;

    // Zero length
    @(negedge clk);
    rsp_q.push_back(rsp_exp(64'h5000, 36'd0, 7'd0, 1'b1));
    push_cmd(64'h5000, 36'd0);
    wait_drain("zero");

    // Reset in the middle of a stream with one command still queued
    @(negedge clk);
    exp_req(64'h2000, 36'd1024); exp_beats(64, 1);
    push_cmd(64'h2000, 36'd1024);
    repeat (8) @(negedge clk);
    push_cmd(64'h6000, 36'd16);
    #1;
    check("mid_stream_valid", 128'(egress_valid), 128'(1));
    check("mid_queue", 128'(cmd_count), 128'(1));
    @(negedge clk);
    abort = 1; rst = 1'b1;
    @(negedge clk); #1;
    check("mrst_request", 128'(master_request), 0);
    check("mrst_egress_valid", 128'(egress_valid), 0);
    check("mrst_dst_rdy", 128'(master_datain_dst_rdy), 0);
    check("mrst_rsp_valid", 128'(rsp_valid), 0);
    check("mrst_busy", 128'(busy), 0);
    check("mrst_count", 128'(cmd_count), 0);
    check("mrst_accept", 128'(cmd_accept), 0);
    @(negedge clk);
    req_q.delete(); eg_q.delete(); rsp_q.delete();
    rx_cnt = tx_cnt;
    abort = 0; rst = 1'b0;
    repeat (2) @(negedge clk);

    // Recovery plus 2^64 wrap: split at the top boundary
    exp_req(64'hFFFF_FFFF_FFFF_FFF0, 36'd16); exp_req(64'h0, 36'd32);
    exp_beats(1, 0); exp_beats(2, 1);
    rsp_q.push_back(rsp_exp(64'hFFFF_FFFF_FFFF_FFF0, 36'd48, 7'd0, 1'b1));
    push_cmd(64'hFFFF_FFFF_FFFF_FFF0, 36'd48);
    wait_drain("wrap");
    #1 check("end_busy", 128'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
